// File: rtl/tri_fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tri_fir_pkg
// Description : Shared state encoding, tap-weight function and width helpers
//               for the triangular FIR smoother.
// Revision    : 1.0 - initial release
// ============================================================================
package tri_fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Triangular weight of tap k: 1,2,..,half+1,..,2,1
    function automatic int coef(input int k, input int half);
        return (k <= half) ? k + 1 : 2 * half + 1 - k;
    endfunction

    function automatic int nsh(input int half);
        return 2 * $clog2(half + 1);
    endfunction

    function automatic int acc_w(input int dw, input int half);
        return dw + nsh(half);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tri_fir_mac.sv
`default_nettype none
// ============================================================================
// Module      : tri_fir_mac
// Description : Combinational weighted sum of the symmetric window using
//               pair pre-adds and constant shift/add weighting.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_fir_mac
    import tri_fir_pkg::*;
#(
    parameter  int DW    = 10,
    parameter  int HALF  = 7,
    localparam int TAPS  = 2 * HALF + 1,
    localparam int ACC_W = acc_w(DW, HALF)
)(
    input  logic [TAPS-1:0][DW-1:0] i_win,
    output logic [ACC_W-1:0]        o_acc
);

    localparam int c_lg = $clog2(HALF + 1);

    logic [ACC_W-1:0] w_term [HALF];

    for (genvar k = 0; k < HALF; k++) begin : g_pair
        logic [DW:0]      w_pre;
        logic [ACC_W-1:0] w_wt;

        assign w_pre = {1'b0, i_win[k]} + {1'b0, i_win[TAPS-1-k]};

        // Every weight is below 2**c_lg, so c_lg partial products suffice
        always_comb begin
            w_wt = '0;
            for (int b = 0; b < c_lg; b++) begin
                if (((coef(k, HALF) >> b) & 1) != 0) begin
                    w_wt = w_wt + (ACC_W'(w_pre) << b);
                end
            end
        end

        assign w_term[k] = w_wt;
    end

    always_comb begin
        o_acc = ACC_W'(i_win[HALF]) << c_lg;
        for (int k = 0; k < HALF; k++) begin
            o_acc = o_acc + w_term[k];
        end
    end

endmodule
`default_nettype wire

// File: rtl/tri_fir_smoother.sv
`default_nettype none
// ============================================================================
// Module      : tri_fir_smoother
// Description : Streaming framed triangular FIR smoother with replicated
//               edges; L outputs per L-sample frame. Define TRI_FIR_NORM_EN
//               for rounded, DW-wide normalised output.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_fir_smoother
    import tri_fir_pkg::*;
#(
    parameter  int DW    = 10,
    parameter  int HALF  = 7,
    localparam int ACC_W = acc_w(DW, HALF),
`ifdef TRI_FIR_NORM_EN
    localparam int OW    = DW
`else
    localparam int OW    = ACC_W
`endif
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [OW-1:0] m_data,
    output logic          m_last
);

    localparam int              c_taps = 2 * HALF + 1;
    localparam int              c_cw   = $clog2(HALF + 2);
    localparam logic [c_cw-1:0] c_full = c_cw'(HALF + 1);
    localparam logic [c_cw-1:0] c_half = c_cw'(HALF);

    state_e                      r_state_q, w_state_d;
    logic [c_cw-1:0]             r_cnt_q, w_cnt_d;
    logic [c_cw-1:0]             r_fcnt_q, w_fcnt_d;
    logic [c_taps-1:0][DW-1:0]   r_win_q, w_win_d;
    logic                        r_m_valid_q, w_m_valid_d;
    logic                        r_m_last_q, w_m_last_d;
    logic [OW-1:0]               r_m_data_q, w_m_data_d;

    logic                        w_step_ok;
    logic                        w_accept;
    logic                        w_emit;
    logic                        w_last;
    logic [ACC_W-1:0]            w_acc;
    logic [OW-1:0]               w_out;

    assign w_step_ok = !r_m_valid_q || m_ready;
    assign s_ready   = w_step_ok && (r_state_q != ST_FLUSH);
    assign w_accept  = s_valid && s_ready;

    assign m_valid = r_m_valid_q;
    assign m_data  = r_m_data_q;
    assign m_last  = r_m_last_q;

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_fcnt_d  = r_fcnt_q;
        w_win_d   = r_win_q;
        w_emit    = 1'b0;
        w_last    = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    for (int k = 0; k < c_taps; k++) begin
                        w_win_d[k] = s_data;
                    end
                    w_cnt_d   = c_cw'(1);
                    w_fcnt_d  = '0;
                    w_state_d = s_last ? ST_FLUSH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    w_win_d = {s_data, r_win_q[c_taps-1:1]};
                    if (r_cnt_q != c_full) begin
                        w_cnt_d = r_cnt_q + 1'b1;
                    end
                    w_emit = (w_cnt_d == c_full);
                    if (s_last) begin
                        w_state_d = ST_FLUSH;
                        w_fcnt_d  = '0;
                    end
                end
            end
            ST_FLUSH: begin
                // Short frames skip the early flush outputs whose centre lies left of sample 0
                if (w_step_ok) begin
                    w_win_d  = {r_win_q[c_taps-1], r_win_q[c_taps-1:1]};
                    w_fcnt_d = r_fcnt_q + 1'b1;
                    w_emit   = (w_fcnt_d >= (c_full - r_cnt_q));
                    if (w_fcnt_d == c_half) begin
                        w_last    = 1'b1;
                        w_state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    tri_fir_mac #(
        .DW   (DW),
        .HALF (HALF)
    ) u_mac (
        .i_win (w_win_d),
        .o_acc (w_acc)
    );

`ifdef TRI_FIR_NORM_EN
    localparam int               c_nsh = nsh(HALF);
    localparam logic [ACC_W:0]   c_rnd = (ACC_W + 1)'(1) << (c_nsh - 1);

    assign w_out = OW'(({1'b0, w_acc} + c_rnd) >> c_nsh);
`else
    assign w_out = w_acc;
`endif

    always_comb begin
        w_m_valid_d = r_m_valid_q;
        w_m_data_d  = r_m_data_q;
        w_m_last_d  = r_m_last_q;
        if (w_emit) begin
            w_m_valid_d = 1'b1;
            w_m_data_d  = w_out;
            w_m_last_d  = w_last;
        end else if (m_ready) begin
            w_m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= ST_IDLE;
            r_cnt_q     <= '0;
            r_fcnt_q    <= '0;
            r_win_q     <= '0;
            r_m_valid_q <= 1'b0;
            r_m_data_q  <= '0;
            r_m_last_q  <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_fcnt_q    <= w_fcnt_d;
            r_win_q     <= w_win_d;
            r_m_valid_q <= w_m_valid_d;
            r_m_data_q  <= w_m_data_d;
            r_m_last_q  <= w_m_last_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tri_fir_smoother.sv
`default_nettype none
// ============================================================================
// Module      : tb_tri_fir_smoother
// Description : Scoreboard bench for tri_fir_smoother (DW=10, HALF=7).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tri_fir_smoother;

    localparam int DW    = 10;
    localparam int HALF  = 7;
    localparam int TAPS  = 2 * HALF + 1;
    localparam int NSH   = 6;
`ifdef TRI_FIR_NORM_EN
    localparam int OW    = DW;
`else
    localparam int OW    = DW + NSH;
`endif

    typedef struct {
        logic [OW-1:0] d;
        logic          l;
        string         nm;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [OW-1:0] m_data;
    logic          m_last;

    exp_t q[$];
    int   xs[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   bp_en    = 1'b0;

    always #5 clk = ~clk;

    tri_fir_smoother #(
        .DW   (DW),
        .HALF (HALF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] to_out(input longint raw);
`ifdef TRI_FIR_NORM_EN
        return OW'((raw + (longint'(1) << (NSH - 1))) >> NSH);
`else
        return OW'(raw);
`endif
    endfunction

    // Direct edge-clamped convolution of the current frame in xs
    function automatic longint model(input int i, input int len);
        longint s;
        s = 0;
        for (int k = 0; k < TAPS; k++) begin
            int j;
            int c;
            j = i - HALF + k;
            if (j < 0) j = 0;
            if (j > len - 1) j = len - 1;
            c = (k <= HALF) ? k + 1 : TAPS - k;
            s += longint'(c) * longint'(xs[j]);
        end
        return s;
    endfunction

    task automatic push(input logic [OW-1:0] d, input logic l, input string nm);
        exp_t e;
        e.d  = d;
        e.l  = l;
        e.nm = nm;
        q.push_back(e);
    endtask

    // Sends the first n samples of a len-sample frame; caller is at posedge+1
    task automatic send(input int len, input int n);
        for (int i = 0; i < n; i++) begin
            bit got;
            got     = 1'b0;
            s_valid = 1'b1;
            s_data  = DW'(xs[i]);
            s_last  = (i == len - 1);
            for (int c = 0; c < 2000 && !got; c++) begin
                @(negedge clk);
                if (s_ready) got = 1'b1;
            end
            if (!got) begin
                n_checks++;
                n_errors++;
                $display("FAIL s_ready_timeout: got no accept for sample %0d, required accept", i);
                break;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic model_frame(input int len, input string nm);
        for (int i = 0; i < len; i++) begin
            push(to_out(model(i, len)), (i == len - 1), nm);
        end
        send(len, len);
    endtask

    task automatic drain(input string nm);
        int c;
        c = 0;
        while (q.size() != 0 && c < 5000) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk({nm, "_drain_left"}, q.size(), 0);
    endtask

    initial begin : m_ready_drv
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : monitor
        exp_t          e;
        bit            held;
        logic [OW-1:0] held_d;
        logic          held_l;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("stall_valid", m_valid, 1);
                    chk("stall_data", m_data, held_d);
                    chk("stall_last", m_last, held_l);
                end
                held = 1'b0;
                if (m_valid && m_ready) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_output: got data=%0d last=%0d, required no output",
                                 m_data, m_last);
                    end else begin
                        e = q.pop_front();
                        chk({e.nm, "_data"}, m_data, e.d);
                        chk({e.nm, "_last"}, m_last, e.l);
                    end
                end else if (m_valid) begin
                    held   = 1'b1;
                    held_d = m_data;
                    held_l = m_last;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int bp_len [3] = '{9, 4, 17};
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Constant frame: every output is 100 * 64
        xs.delete();
        for (int i = 0; i < 20; i++) xs.push_back(100);
        for (int i = 0; i < 20; i++) push(to_out(6400), (i == 19), "const");
        send(20, 20);

        // Impulse at 16: triangle 1..8..1 over outputs 9..23
        xs.delete();
        for (int i = 0; i < 32; i++) xs.push_back((i == 16) ? 1 : 0);
        for (int i = 0; i < 32; i++) begin
            int v;
            v = 0;
            if (i >= 9 && i <= 16) v = i - 8;
            if (i > 16 && i <= 23) v = 24 - i;
            push(to_out(longint'(v)), (i == 31), "impulse");
        end
        send(32, 32);

        // Ramp: endpoints 84, centre 512, tail 876
        xs.delete();
        for (int i = 0; i < 16; i++) xs.push_back(i);
        for (int i = 0; i < 16; i++) begin
            longint v;
            v = model(i, 16);
            if (i == 0)  v = 84;
            if (i == 8)  v = 512;
            if (i == 15) v = 876;
            push(to_out(v), (i == 15), "ramp");
        end
        send(16, 16);

        xs.delete();
        xs.push_back(5);
        push(to_out(320), 1'b1, "len1");
        send(1, 1);

        xs.delete();
        xs.push_back(3);
        xs.push_back(7);
        xs.push_back(11);
        model_frame(3, "len3");
        drain("directed");

        bp_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            xs.delete();
            for (int i = 0; i < bp_len[f]; i++) xs.push_back(int'($urandom_range(0, 1023)));
            model_frame(bp_len[f], "bp");
        end
        drain("bp");
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        // Reset after 10 samples of a 20-sample frame
        xs.delete();
        for (int i = 0; i < 20; i++) xs.push_back(50 * i + 7);
        for (int i = 0; i < 3; i++) push(to_out(model(i, 20)), 1'b0, "partial");
        send(20, 10);
        reset = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;

        xs.delete();
        for (int i = 0; i < 12; i++) xs.push_back(1023 - 60 * i);
        model_frame(12, "post_rst");
        drain("post_rst");

        repeat (20) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
